// File: rtl/conv_pe_array_seq_if.sv
// Handshake/bus bundle for conv_pe_array_seq.
//   start/busy/done          : run control
//   w_valid/w_ready/w_data   : weight beats, one DATA_W weight per PE
//   x_valid/x_ready/x_data   : broadcast activation beats
//   ofm_wr/ofm_addr/ofm_data : OFM write port, one DATA_W result per PE
// master = activation/weight source side, slave = the PE array.
interface conv_pe_array_seq_if #(
  parameter int unsigned N_PE   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     w_valid;
  logic                     w_ready;
  logic [N_PE*DATA_W-1:0]   w_data;
  logic                     x_valid;
  logic                     x_ready;
  logic [DATA_W-1:0]        x_data;
  logic                     ofm_wr;
  logic [ADDR_W-1:0]        ofm_addr;
  logic [N_PE*DATA_W-1:0]   ofm_data;

  modport master (
    output start, w_valid, w_data, x_valid, x_data,
    input  busy, done, w_ready, x_ready, ofm_wr, ofm_addr, ofm_data
  );

  modport slave (
    input  start, w_valid, w_data, x_valid, x_data,
    output busy, done, w_ready, x_ready, ofm_wr, ofm_addr, ofm_data
  );
endinterface

// File: rtl/conv_pe_array_seq.sv
// Parametrised layer-2 convolution PE array with internal sequencer.
// N_PE PEs share one broadcast activation stream; each holds a TAPS-deep
// filter and one accumulator. A run loads the filters, then for each of
// N_PIX pixels accumulates TAPS activations and writes all N_PE requantised
// results to the OFM in one write.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : conv_pe_array_seq_if.slave (run control, weight/activation
//          ready/valid streams, OFM write port); all outputs registered
// Optional feature: define CONV_PE_RELU_EN to clamp negative results to 0
// before saturation.
module conv_pe_array_seq #(
  parameter int unsigned N_PE   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned TAPS   = 9,
  parameter int unsigned N_PIX  = 64,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned SHIFT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  conv_pe_array_seq_if.slave  bus
);

  localparam int unsigned TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [TAP_W-1:0]  TAP_LAST = TAP_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(N_PIX - 1);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  // Bitwise complement of 2^(k)-1 is -2^k in two's complement.
  localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [2:0] {IDLE, LOAD_W, MAC, WRITE, FIN} state_t;

  state_t state_q, state_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic w_ready_q, w_ready_d;
  logic x_ready_q, x_ready_d;
  logic ofm_wr_q, ofm_wr_d;

  logic [TAP_W-1:0]         tap_q;
  logic [ADDR_W-1:0]        pix_q;
  logic [ADDR_W-1:0]        ofm_addr_q;
  logic [N_PE*DATA_W-1:0]   ofm_data_q, ofm_data_d;

  logic signed [DATA_W-1:0] wgt_q [N_PE][TAPS];
  logic signed [ACC_W-1:0]  acc_q [N_PE];
  logic signed [ACC_W-1:0]  acc_d [N_PE];
  logic signed [PROD_W-1:0] mul   [N_PE];
  logic signed [ACC_W-1:0]  prod  [N_PE];
  logic signed [DATA_W-1:0] x_s;

  logic w_fire, x_fire, tap_last;

  assign x_s      = bus.x_data;
  assign w_fire   = bus.w_valid && w_ready_q;
  assign x_fire   = bus.x_valid && x_ready_q;
  assign tap_last = (tap_q == TAP_LAST);

  // Shift (floor), optional ReLU, then saturate to DATA_W.
  function automatic logic [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    sh = a >>> SHIFT;
`ifdef CONV_PE_RELU_EN
    if (sh[ACC_W-1]) sh = '0;
`endif
    if (sh > Q_MAX)      sh = Q_MAX;
    else if (sh < Q_MIN) sh = Q_MIN;
    return sh[DATA_W-1:0];
  endfunction

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_ready_q <= 1'b0;
      x_ready_q <= 1'b0;
      ofm_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_ready_q <= w_ready_d;
      x_ready_q <= x_ready_d;
      ofm_wr_q  <= ofm_wr_d;
    end
  end

  // Next state; outputs are decoded from the next state so they line up
  // with the state they belong to once registered.
  always_comb begin
    state_d   = state_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    w_ready_d = 1'b0;
    x_ready_d = 1'b0;
    ofm_wr_d  = 1'b0;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = LOAD_W;
      LOAD_W:  if (w_fire && tap_last) state_d = MAC;
      MAC:     if (x_fire && tap_last) state_d = WRITE;
      WRITE:   state_d = (pix_q == PIX_LAST) ? FIN : MAC;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d == LOAD_W) || (state_d == MAC) || (state_d == WRITE);
    done_d    = (state_d == FIN);
    w_ready_d = (state_d == LOAD_W);
    x_ready_d = (state_d == MAC);
    ofm_wr_d  = (state_d == WRITE);
  end

  // Per-PE MAC and requantisation of the post-beat accumulator value.
  always_comb begin
    ofm_data_d = '0;
    for (int i = 0; i < N_PE; i++) begin
      mul[i]   = PROD_W'(x_s) * PROD_W'(wgt_q[i][tap_q]);
      prod[i]  = ACC_W'(mul[i]);
      acc_d[i] = (tap_q == '0) ? prod[i] : acc_q[i] + prod[i];
      ofm_data_d[i*DATA_W +: DATA_W] = requant(acc_d[i]);
    end
  end

  // Filters, accumulators, counters and OFM output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_q      <= '0;
      pix_q      <= '0;
      ofm_addr_q <= '0;
      ofm_data_q <= '0;
      for (int i = 0; i < N_PE; i++) begin
        acc_q[i] <= '0;
        for (int t = 0; t < TAPS; t++) wgt_q[i][t] <= '0;
      end
    end else begin
      if ((state_q == IDLE) && bus.start) begin
        tap_q      <= '0;
        pix_q      <= '0;
        ofm_addr_q <= '0;
      end
      if (w_fire) begin
        for (int i = 0; i < N_PE; i++) wgt_q[i][tap_q] <= bus.w_data[i*DATA_W +: DATA_W];
        tap_q <= tap_last ? '0 : tap_q + 1'b1;
      end
      if (x_fire) begin
        for (int i = 0; i < N_PE; i++) acc_q[i] <= acc_d[i];
        tap_q <= tap_last ? '0 : tap_q + 1'b1;
        // Capture results on the last beat so they are valid during WRITE.
        if (tap_last) begin
          ofm_data_q <= ofm_data_d;
          ofm_addr_q <= pix_q;
        end
      end
      if (state_q == WRITE) pix_q <= pix_q + 1'b1;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.w_ready  = w_ready_q;
  assign bus.x_ready  = x_ready_q;
  assign bus.ofm_wr   = ofm_wr_q;
  assign bus.ofm_addr = ofm_addr_q;
  assign bus.ofm_data = ofm_data_q;

endmodule

// File: doc/conv_pe_array_seq.md
Name: conv_pe_array_seq

Overview:
- Parametrised successor to the fixed four-PE layer-2 convolution datapath.
- N_PE processing elements share one broadcast activation stream. Each PE holds its own TAPS-deep filter and one accumulator.
- An internal sequencer loads filters, accumulates one output pixel per TAPS accepted activations, then requantises and writes all N_PE results to the OFM banks in one write.
- Sits between the layer-1 OFM readers (activation source) and the layer-2 OFM memories.

Parameters:
- N_PE, 4, number of PEs / output channels
- DATA_W, 8, signed activation, weight and OFM word width
- ACC_W, 24, signed accumulator width; must be >= 2*DATA_W + clog2(TAPS)
- TAPS, 9, MAC beats per output pixel (kernel taps x input channels)
- N_PIX, 64, output pixels per run
- ADDR_W, 8, OFM address width; must satisfy 2^ADDR_W >= N_PIX
- SHIFT, 4, requantisation arithmetic right shift

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle run request
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the run completes
- w_valid  in  1  weight beat valid
- w_ready  out  1  weight beat accepted when w_valid && w_ready
- w_data  in  N_PE*DATA_W  one signed weight per PE; PE i uses slice i
- x_valid  in  1  activation beat valid
- x_ready  out  1  activation beat accepted when x_valid && x_ready
- x_data  in  DATA_W  signed activation, broadcast to all PEs
- ofm_wr  out  1  OFM write strobe
- ofm_addr  out  ADDR_W  OFM write address
- ofm_data  out  N_PE*DATA_W  requantised results; PE i in slice i

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - busy, done, w_ready, x_ready and ofm_wr are 0; ofm_addr and ofm_data are 0.
  - Filters, accumulators, tap counter and pixel counter are cleared.
  - Reset mid-run aborts the run with no further writes and no done pulse.
- FSM states: IDLE, LOAD_W, MAC, WRITE, FIN.
  - IDLE: start=1 -> LOAD_W, busy=1. start while busy is ignored.
  - LOAD_W: w_ready=1. Each accepted beat stores w_data into filter tap t (t = 0..TAPS-1). After tap TAPS-1 -> MAC with t=0.
  - MAC: x_ready=1. Each accepted beat computes, per PE, prod = x_data * weight[t], a signed DATA_W x DATA_W product sign-extended to ACC_W.
    - At t=0 the accumulator loads prod. Otherwise it loads acc + prod, wrapping in ACC_W.
    - After tap TAPS-1 -> WRITE.
  - WRITE (exactly 1 cycle): ofm_wr=1, ofm_addr = pixel counter, ofm_data = requant(acc) per PE.
    - Pixel counter then increments.
    - If that was pixel N_PIX-1 -> FIN; else -> MAC with t=0.
  - FIN (1 cycle): done=1, busy=0 in the same cycle, then -> IDLE.
- Latency: ofm_wr asserts on the cycle after the TAPS-th accepted activation.
- Ready/valid: no beat is lost or duplicated under arbitrary valid gaps.
  - x_ready is 0 outside MAC; w_ready is 0 outside LOAD_W.
  - Beats presented while not ready are not consumed.
- requant(acc): arithmetic right shift by SHIFT (floor toward -inf), then saturate to signed [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- ofm_data and ofm_addr are registered and hold their last values outside WRITE. ofm_addr returns to 0 at the next start.
- Filters persist across runs only until the next LOAD_W overwrites them.

Optional Feature:
- Macro: CONV_PE_RELU_EN.
- Defined: requant applies ReLU after the shift, so the saturation range becomes [0, 2^(DATA_W-1)-1] and negative results write 0.
- Undefined: signed saturation only, as above.

Test Plan:
- Basic run (N_PIX=2, TAPS=9): all weights 1, all x=2 -> acc 18, two writes at addr 0 and 1 with every slice = 1; done pulses one cycle after the second write; busy drops with done.
- Negative floor: PE0 weights -1, others 0, x=100 -> PE0 acc -900, writes -57 (0xC7); other slices 0.
- Saturation: weights 127, x=127 -> acc 145161, >>4 = 9072, writes 127. With weights -128, x=127 -> writes -128.
- Backpressure: x_valid toggled 1-0-0-1 with random gaps, and w_valid driven before LOAD_W -> identical results to the gap-free run; no early weight consumption; ofm_wr exactly one cycle after the 9th accepted x beat.
- Reset mid-MAC: assert rst low after 4 accepted x beats -> outputs 0 immediately (asynchronously); no ofm_wr and no done afterwards. A new start performs a clean full run from addr 0.
- CONV_PE_RELU_EN defined: repeat the negative-floor case -> PE0 writes 0. Repeat the saturation case -> 127 unchanged.
